// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state type, default bit period, parity helper.
// Used by both the transmitter and the receiver side of the UART.
// Pure declarations; no logic of its own.
package uart_pkg;

   // 50 MHz core clock / 115200 baud
   localparam int CLKS_PER_BIT_DEFAULT = 434;

   // Frame FSM states, shared with the receiver so both sides decode alike
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_e;

   // Even parity: the bit that makes the total count of ones even
   function automatic logic even_parity(input logic [7:0] i_byte);
      return ^i_byte;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period strobe generator: one-cycle o_tick every CLKS_PER_BIT enabled cycles.
// Latency: o_tick is combinational from the counter; i_restart zeroes it on the next edge.
// No backpressure; the counter simply holds while i_en is low.
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_restart,
   input  logic i_en,
   output logic o_tick
);

   localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] r_cnt;

   // Count cycles within the current bit; wrap only at the bit boundary
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_restart) begin
         r_cnt <= '0;
      end else if (i_en) begin
         if (r_cnt == LAST) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   // Strobe on the last cycle of a bit; suppressed while a new frame restarts timing
   assign o_tick = i_en && (r_cnt == LAST) && !i_restart;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits LSB first, optional even parity, 1 or 2 stop bits.
// Latency: start bit appears on tx the cycle after the tx_valid/tx_ready handshake.
// Backpressure: tx_ready is high only in IDLE; tx_valid is ignored while a frame is in flight.
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
   parameter int PARITY_EN    = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx,
   output logic       busy
);

   // Index of the final stop bit (0 for one stop bit, 1 for two)
   localparam logic LAST_STOP  = (STOP_BITS == 2);
   localparam logic HAS_PARITY = (PARITY_EN != 0);

   uart_state_e r_state;
   logic [7:0]  r_data;
   logic [2:0]  r_bit_idx;
   logic        r_stop_idx;
   logic        r_tx;
   logic        r_ready;
   logic        r_busy;

   logic        w_accept;
   logic        w_tick;

   // A byte is taken only when the FSM is idle and has advertised readiness
   assign w_accept = (r_state == IDLE) && r_ready && tx_valid;

   // Bit timing restarts with each accepted byte so the start bit is full length
   uart_baud_tick #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud_tick (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_restart (w_accept),
      .i_en      (r_busy),
      .o_tick    (w_tick)
   );

   // Frame FSM; tx is produced from a register so the line never glitches
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_data     <= '0;
         r_bit_idx  <= '0;
         r_stop_idx <= 1'b0;
         r_tx       <= 1'b1;
         r_ready    <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               // Readiness comes up one edge after reset release and stays up while idle
               r_ready <= 1'b1;
               r_tx    <= 1'b1;
               if (w_accept) begin
                  r_data  <= tx_data;
                  r_state <= START;
                  r_tx    <= 1'b0;
                  r_busy  <= 1'b1;
                  r_ready <= 1'b0;
               end
            end

            START: begin
               if (w_tick) begin
                  r_state   <= DATA;
                  r_bit_idx <= '0;
                  r_tx      <= r_data[0];
               end
            end

            DATA: begin
               if (w_tick) begin
                  if (r_bit_idx == 3'd7) begin
                     if (HAS_PARITY) begin
                        r_state <= PARITY;
                        r_tx    <= even_parity(r_data);
                     end else begin
                        r_state    <= STOP;
                        r_stop_idx <= 1'b0;
                        r_tx       <= 1'b1;
                     end
                  end else begin
                     r_bit_idx <= r_bit_idx + 3'd1;
                     r_tx      <= r_data[r_bit_idx + 3'd1];
                  end
               end
            end

            PARITY: begin
               if (w_tick) begin
                  r_state    <= STOP;
                  r_stop_idx <= 1'b0;
                  r_tx       <= 1'b1;
               end
            end

            STOP: begin
               if (w_tick) begin
                  if (r_stop_idx == LAST_STOP) begin
                     // Returning to IDLE re-opens the handshake on the same edge
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                     r_ready <= 1'b1;
                  end else begin
                     r_stop_idx <= 1'b1;
                  end
               end
            end

            default: begin
               r_state <= IDLE;
               r_tx    <= 1'b1;
               r_busy  <= 1'b0;
               r_ready <= 1'b0;
            end
         endcase
      end
   end

   assign tx       = r_tx;
   assign tx_ready = r_ready;
   assign busy     = r_busy;

endmodule
